// File: rtl/cpu_defs_pkg.sv
// Shared fetch-slice definitions: fetch FSM encoding, nop word,
// default reset PC and the bundle latched for the ID stage.
package cpu_defs_pkg;

    typedef enum logic [1:0] {
        IF_IDLE = 2'd0,
        IF_REQ  = 2'd1,
        IF_WAIT = 2'd2,
        IF_HOLD = 2'd3
    } if_state_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        fault;
    } if_slot_t;

endpackage

// File: rtl/if_addr_check.sv
// Combinational fetch-address legality check: word aligned and
// inside [IM_BASE, IM_BASE+IM_BYTES).
module if_addr_check #(
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter logic [31:0] IM_BYTES = 32'h0000_1000
) (
    input  logic [31:0] addr,
    output logic        addr_ok
);

    logic [32:0] addr_x;
    logic [32:0] lo_x;
    logic [32:0] hi_x;

    // 33-bit compare so a region ending at 4 GiB cannot wrap
    assign addr_x = {1'b0, addr};
    assign lo_x   = {1'b0, IM_BASE};
    assign hi_x   = {1'b0, IM_BASE} + {1'b0, IM_BYTES};

    assign addr_ok = (addr[1:0] == 2'b00)
                   && (addr_x >= lo_x)
                   && (addr_x < hi_x);

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: one outstanding imem fetch, result held for ID.
// Define FETCH_ADDR_CHECK_EN to fault illegal fetch addresses locally.
module if_fetch_unit
    import cpu_defs_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter logic [31:0] IM_BYTES = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic        pc_en,
    input  logic        redirect,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        if_fault
);

    if_state_e   state_q, state_d;
    logic        kill_q, kill_d;
    logic [31:0] req_addr_q, req_addr_d;
    if_slot_t    slot_q, slot_d;
    logic        addr_ok;
    logic        kill_now;
    logic        req_valid_d;
    logic        pc_en_d;

`ifdef FETCH_ADDR_CHECK_EN
    if_addr_check #(
        .IM_BASE  (IM_BASE),
        .IM_BYTES (IM_BYTES)
    ) u_addr_check (
        .addr    (req_addr_q),
        .addr_ok (addr_ok)
    );
`else
    logic unused_cfg;
    assign unused_cfg = ^{IM_BASE, IM_BYTES};
    assign addr_ok    = 1'b1;
`endif

    // a redirect this cycle kills the in-flight fetch just like a stored kill
    assign kill_now = kill_q | redirect;

    always_comb begin
        state_d     = state_q;
        kill_d      = kill_q;
        req_addr_d  = req_addr_q;
        slot_d      = slot_q;
        req_valid_d = 1'b0;
        pc_en_d     = redirect;
        unique case (state_q)
            IF_IDLE: begin
                state_d    = IF_REQ;
                req_addr_d = pc;
            end
            IF_REQ: begin
                if (!addr_ok) begin
                    pc_en_d = redirect | ~kill_q;
                    if (kill_now) begin
                        state_d = IF_IDLE;
                        kill_d  = 1'b0;
                    end else begin
                        state_d = IF_HOLD;
                        slot_d  = '{instr: NOP_INSTR,
                                    pc:    req_addr_q,
                                    fault: 1'b1};
                    end
                end else begin
                    req_valid_d = 1'b1;
                    kill_d      = kill_now;
                    if (imem_req_ready) begin
                        state_d = IF_WAIT;
                        pc_en_d = redirect | ~kill_q;
                    end
                end
            end
            IF_WAIT: begin
                if (redirect) begin
                    kill_d = 1'b1;
                end
                if (imem_rsp_valid) begin
                    if (kill_now) begin
                        state_d = IF_IDLE;
                        kill_d  = 1'b0;
                    end else begin
                        state_d = IF_HOLD;
                        slot_d  = '{instr: imem_rsp_data,
                                    pc:    req_addr_q,
                                    fault: 1'b0};
                    end
                end
            end
            IF_HOLD: begin
                if (redirect) begin
                    state_d = IF_IDLE;
                end else if (if_ready) begin
                    state_d    = IF_REQ;
                    req_addr_d = pc;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IF_IDLE;
            kill_q     <= 1'b0;
            req_addr_q <= '0;
            slot_q     <= '{instr: NOP_INSTR,
                            pc:    RESET_PC,
                            fault: 1'b0};
        end else begin
            state_q    <= state_d;
            kill_q     <= kill_d;
            req_addr_q <= req_addr_d;
            slot_q     <= slot_d;
        end
    end

    assign pc_en          = pc_en_d & ~reset;
    assign imem_req_valid = req_valid_d & ~reset;
    assign imem_req_addr  = req_addr_q;
    assign if_valid       = (state_q == IF_HOLD) & ~reset;
    assign if_instr       = slot_q.instr;
    assign if_pc          = slot_q.pc;
    assign if_fault       = slot_q.fault;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed fetch scenarios, then random
// memory/ID/redirect traffic scored against a program-order model.
module tb_if_fetch_unit;

    localparam logic [31:0] RPC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        pc_en;
    logic        redirect;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_fault;

    always #5 clk = ~clk;

    if_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .pc             (pc),
        .pc_en          (pc_en),
        .redirect       (redirect),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_fault       (if_fault)
    );

    int vectors = 0;
    int miscompares = 0;

    // environment: PC register, memory responder, program-order model
    logic [31:0] exp_pc, pc_nx, pend_addr, tgt, prv_addr;
    bit          outstanding, prv_stall, spur_en;
    int          pend_cnt, lat_min, lat_max, ready_prob, accepted;

    // values seen in the most recently completed cycle
    logic        o_req_valid, o_pc_en, o_if_valid, o_fault;
    logic [31:0] o_addr, o_instr, o_ifpc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_3000) return 32'h2401_0005;
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    function automatic logic addr_legal(input logic [31:0] a);
`ifdef FETCH_ADDR_CHECK_EN
        return (a[1:0] == 2'b00) && (a >= 32'h3000) && (a < 32'h4000);
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [31:0] exp_instr(input logic [31:0] a);
        return addr_legal(a) ? mem_word(a) : 32'h0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        o_req_valid = imem_req_valid;
        o_pc_en     = pc_en;
        o_if_valid  = if_valid;
        o_fault     = if_fault;
        o_addr      = imem_req_addr;
        o_instr     = if_instr;
        o_ifpc      = if_pc;
        if (reset) begin
            outstanding = 0;
            prv_stall   = 0;
            exp_pc      = RPC;
            pc_nx       = RPC;
        end else begin
            if (prv_stall) begin
                chk("req_hold_valid", imem_req_valid, 1);
                chk("req_hold_addr", imem_req_addr, prv_addr);
            end
            prv_stall = imem_req_valid && !imem_req_ready;
            prv_addr  = imem_req_addr;
`ifdef FETCH_ADDR_CHECK_EN
            if (imem_req_valid)
                chk("req_addr_legal", addr_legal(imem_req_addr), 1);
`endif
            if (redirect) begin
                chk("redirect_pc_en", pc_en, 1);
                exp_pc = tgt;
            end else if (if_valid && if_ready) begin
                chk("id_pc", if_pc, exp_pc);
                chk("id_instr", if_instr, exp_instr(exp_pc));
                chk("id_fault", if_fault, !addr_legal(exp_pc));
                exp_pc = exp_pc + 4;
                accepted++;
            end
            if (imem_rsp_valid && outstanding) outstanding = 0;
            if (imem_req_valid && imem_req_ready) begin
                chk("one_outstanding", outstanding, 0);
                outstanding = 1;
                pend_addr   = imem_req_addr;
                pend_cnt    = $urandom_range(lat_max, lat_min);
            end
            pc_nx = redirect ? tgt : (pc_en ? pc + 32'd4 : pc);
        end
        @(posedge clk);
        #1;
        pc = pc_nx;
        imem_req_ready = ($urandom_range(99, 0) < ready_prob);
        if (outstanding && pend_cnt == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend_addr);
        end else begin
            if (outstanding) pend_cnt--;
            imem_rsp_valid = spur_en && !outstanding
                           && ($urandom_range(7, 0) == 0);
            imem_rsp_data  = $urandom;
        end
    endtask

    task automatic start_at(input logic [31:0] a);
        reset    = 1'b1;
        redirect = 1'b0;
        if_ready = 1'b0;
        repeat (2) cycle();
        reset  = 1'b0;
        pc     = a;
        exp_pc = a;
    endtask

`ifdef FETCH_ADDR_CHECK_EN
    task automatic fault_case(input logic [31:0] a);
        start_at(a);
        cycle();
        cycle();
        chk("flt_no_req", o_req_valid, 0);
        chk("flt_pc_en", o_pc_en, 1);
        cycle();
        chk("flt_valid", o_if_valid, 1);
        chk("flt_fault", o_fault, 1);
        chk("flt_instr", o_instr, 32'h0);
        chk("flt_pc", o_ifpc, a);
        if_ready = 1'b1;
        cycle();
        if_ready = 1'b0;
    endtask
`endif

    initial begin
        reset          = 1'b1;
        pc             = RPC;
        redirect       = 1'b0;
        if_ready       = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        tgt            = RPC;
        spur_en        = 0;
        lat_min        = 0;
        lat_max        = 0;
        ready_prob     = 100;
        accepted       = 0;

        // reset state and first fetch latency
        start_at(RPC);
        chk("rst_if_valid", o_if_valid, 0);
        chk("rst_req_valid", o_req_valid, 0);
        chk("rst_pc_en", o_pc_en, 0);
        chk("rst_addr", o_addr, 32'h0);
        chk("rst_instr", o_instr, 32'h0);
        chk("rst_if_pc", o_ifpc, RPC);
        chk("rst_fault", o_fault, 0);
        cycle();
        chk("t1_idle_req", o_req_valid, 0);
        cycle();
        chk("t1_req_valid", o_req_valid, 1);
        chk("t1_req_addr", o_addr, 32'h3000);
        chk("t1_pc_en", o_pc_en, 1);
        cycle();
        chk("t1_wait_pc_en", o_pc_en, 0);
        chk("t1_wait_valid", o_if_valid, 0);
        cycle();
        chk("t1_if_valid", o_if_valid, 1);
        chk("t1_if_pc", o_ifpc, 32'h3000);
        chk("t1_if_instr", o_instr, 32'h2401_0005);
        chk("t1_if_fault", o_fault, 0);

        // ID stalls in HOLD
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("t3_valid", o_if_valid, 1);
            chk("t3_pc", o_ifpc, 32'h3000);
            chk("t3_instr", o_instr, 32'h2401_0005);
            chk("t3_no_req", o_req_valid, 0);
            chk("t3_pc_en", o_pc_en, 0);
        end

        // memory stalls in REQ
        ready_prob = 0;
        if_ready   = 1'b1;
        cycle();
        if_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) ready_prob = 100;
            cycle();
            chk("t2_valid", o_req_valid, 1);
            chk("t2_addr", o_addr, 32'h3004);
            chk("t2_pc_en", o_pc_en, 0);
        end
        cycle();
        chk("t2_accept_pc_en", o_pc_en, 1);
        cycle();
        chk("t2_wait_pc_en", o_pc_en, 0);
        cycle();
        chk("t2_if_valid", o_if_valid, 1);
        chk("t2_if_pc", o_ifpc, 32'h3004);
        chk("t2_if_instr", o_instr, mem_word(32'h3004));

        // redirect while the next fetch waits on memory
        if_ready = 1'b1;
        cycle();
        if_ready = 1'b0;
        lat_min  = 2;
        lat_max  = 2;
        cycle();
        chk("t4_req_addr", o_addr, 32'h3008);
        redirect = 1'b1;
        tgt      = 32'h3100;
        cycle();
        chk("t4_pc_en", o_pc_en, 1);
        redirect = 1'b0;
        lat_min  = 0;
        lat_max  = 0;
        repeat (3) begin
            cycle();
            chk("t4_dropped", o_if_valid, 0);
        end
        cycle();
        chk("t4_req_valid", o_req_valid, 1);
        chk("t4_req_addr2", o_addr, 32'h3100);
        cycle();
        cycle();
        chk("t4_if_valid", o_if_valid, 1);
        chk("t4_if_pc", o_ifpc, 32'h3100);

        // redirect beats if_ready in HOLD
        redirect = 1'b1;
        tgt      = 32'h3200;
        if_ready = 1'b1;
        cycle();
        chk("t5_pc_en", o_pc_en, 1);
        redirect = 1'b0;
        if_ready = 1'b0;
        cycle();
        chk("t5_valid_drop", o_if_valid, 0);
        cycle();
        chk("t5_req_addr", o_addr, 32'h3200);
        cycle();
        cycle();
        chk("t5_if_pc", o_ifpc, 32'h3200);
        chk("t5_if_instr", o_instr, mem_word(32'h3200));
        if_ready = 1'b1;
        cycle();
        if_ready = 1'b0;

`ifdef FETCH_ADDR_CHECK_EN
        fault_case(32'h3002);
        fault_case(32'h2FFC);
`endif

        // random traffic against the program-order model
        start_at(RPC);
        spur_en    = 1;
        lat_min    = 0;
        lat_max    = 3;
        ready_prob = 60;
        accepted   = 0;
        for (int i = 0; i < 3000; i++) begin
            if_ready = ($urandom_range(99, 0) < 70);
            redirect = 1'b0;
            if ((imem_req_valid || outstanding || if_valid)
                && $urandom_range(11, 0) == 0) begin
                redirect = 1'b1;
                tgt = 32'h2F00 + 4 * $urandom_range(1100, 0);
                if ($urandom_range(9, 0) == 0) tgt = tgt + 2;
            end
            cycle();
        end
        redirect = 1'b0;
        if_ready = 1'b0;
        chk("rand_progress", accepted >= 100, 1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
